// File: rtl/rs_issue_if.sv
// Bundle of dispatch, CDB, issue and status signals between the dispatch/ex side and the reservation station.
// Latency: none, wires only.
// Backpressure: dis_ready from the station, iss_ready from ex.
// Ports: flush; dis_* dispatch bus with dis_valid/dis_ready; cdb_* result broadcast;
//        iss_* issue bus with iss_valid/iss_ready; count (occupied entries).
// Modports: master drives dispatch/CDB/iss_ready; slave is the station.
interface rs_issue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;

  logic             dis_valid;
  logic             dis_ready;
  logic [2:0]       dis_unit;
  logic [9:0]       dis_op;
  logic [31:0]      dis_pc;
  logic [TAG_W-1:0] dis_tag;
  logic             dis_rj;
  logic             dis_rk;
  logic [TAG_W-1:0] dis_qj;
  logic [TAG_W-1:0] dis_qk;
  logic [31:0]      dis_vj;
  logic [31:0]      dis_vk;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             iss_valid;
  logic             iss_ready;
  logic [2:0]       iss_unit;
  logic [9:0]       iss_op;
  logic [31:0]      iss_pc;
  logic [31:0]      iss_vj;
  logic [31:0]      iss_vk;
  logic [TAG_W-1:0] iss_tag;

  logic [CW-1:0]    count;

  modport master (
    output flush, dis_valid, dis_unit, dis_op, dis_pc, dis_tag,
           dis_rj, dis_rk, dis_qj, dis_qk, dis_vj, dis_vk,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  dis_ready, iss_valid, iss_unit, iss_op, iss_pc,
           iss_vj, iss_vk, iss_tag, count
  );

  modport slave (
    input  flush, dis_valid, dis_unit, dis_op, dis_pc, dis_tag,
           dis_rj, dis_rk, dis_qj, dis_qk, dis_vj, dis_vk,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output dis_ready, iss_valid, iss_unit, iss_op, iss_pc,
           iss_vj, iss_vk, iss_tag, count
  );
endinterface

// File: rtl/rs_issue.sv
// Reservation station: holds dispatched ops, captures CDB operands, issues the oldest ready entry to ex.
// Latency: dispatch of a ready op -> iss_valid next cycle; CDB wake at edge t -> issue-eligible after t.
// Backpressure: dis_ready low when full (issue does not free a slot same cycle); iss_* held while !iss_ready.
// Ports: clk, reset (async, active-high); rs (rs_issue_if.slave) carrying flush, dispatch, CDB,
//        issue and count.
module rs_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       reset,
  rs_issue_if.slave rs
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]       unit;
    logic [9:0]       op;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
    logic             rj;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vj;
    logic             rk;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vk;
  } ent_t;

  ent_t             ent   [DEPTH];
  logic [DEPTH-1:0] busy;
  // older[i][j] = 1 when entry i was dispatched before entry j. A dispatch into
  // k clears row k and sets column k, so the relation is always consistent for
  // busy entries and never wraps, independent of index or dispatch count.
  logic [DEPTH-1:0] older [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] sel;
  logic [IW-1:0]    free_idx;
  logic             do_dis;
  logic             do_iss;
  logic             byp_j;
  logic             byp_k;
  ent_t             new_ent;
  ent_t             iss_ent;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = busy[i] & ent[i].rj & ent[i].rk;
    end
  end

  // An entry is selected when it is ready and no other ready entry is older.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (rdy[j] && older[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
    end
  end

  // Zero when nothing is selected, so the data outputs read 0 out of reset.
  always_comb begin
    iss_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) iss_ent = ent[i];
    end
  end

  // A producer broadcasting in the dispatch cycle would otherwise be missed.
  always_comb begin
    byp_j = rs.cdb_valid & ~rs.dis_rj & (rs.dis_qj == rs.cdb_tag);
    byp_k = rs.cdb_valid & ~rs.dis_rk & (rs.dis_qk == rs.cdb_tag);
    new_ent      = '0;
    new_ent.unit = rs.dis_unit;
    new_ent.op   = rs.dis_op;
    new_ent.pc   = rs.dis_pc;
    new_ent.tag  = rs.dis_tag;
    new_ent.rj   = rs.dis_rj | byp_j;
    new_ent.qj   = rs.dis_qj;
    new_ent.vj   = byp_j ? rs.cdb_value : rs.dis_vj;
    new_ent.rk   = rs.dis_rk | byp_k;
    new_ent.qk   = rs.dis_qk;
    new_ent.vk   = byp_k ? rs.cdb_value : rs.dis_vk;
  end

  // dis_ready looks only at the registered count: an issue this cycle does not make room.
  assign rs.dis_ready = (count_q < CW'(DEPTH));
  assign rs.iss_valid = (|rdy) & ~rs.flush;
  assign rs.iss_unit  = iss_ent.unit;
  assign rs.iss_op    = iss_ent.op;
  assign rs.iss_pc    = iss_ent.pc;
  assign rs.iss_vj    = iss_ent.vj;
  assign rs.iss_vk    = iss_ent.vk;
  assign rs.iss_tag   = iss_ent.tag;
  assign rs.count     = count_q;

  assign do_dis = rs.dis_valid & rs.dis_ready & ~rs.flush;
  assign do_iss = rs.iss_valid & rs.iss_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]   <= '0;
        older[i] <= '0;
      end
    end else if (rs.flush) begin
      busy    <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs.cdb_valid && busy[i] && !ent[i].rj && (ent[i].qj == rs.cdb_tag)) begin
          ent[i].rj <= 1'b1;
          ent[i].vj <= rs.cdb_value;
        end
        if (rs.cdb_valid && busy[i] && !ent[i].rk && (ent[i].qk == rs.cdb_tag)) begin
          ent[i].rk <= 1'b1;
          ent[i].vk <= rs.cdb_value;
        end
        if (do_iss && sel[i]) busy[i] <= 1'b0;
        if (do_dis) begin
          if (free_idx == IW'(i)) begin
            ent[i]   <= new_ent;
            busy[i]  <= 1'b1;
            older[i] <= '0;
          end else begin
            older[i][free_idx] <= 1'b1;
          end
        end
      end
      case ({do_dis, do_iss})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: doc/rs_issue.md
Name: rs_issue

Overview:
- Reservation station that feeds the execute stage: it is the issue side of the ex interface (Unit, Op, pc, Vj, Vk).
- Accepts dispatched instructions whose source operands may still be pending, captures operands broadcast on the common data bus (CDB), and issues the oldest fully-ready entry to ex over a valid/ready handshake.
- Flushed on branch misprediction.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..16).
- TAG_W, 4, width of ROB/CDB producer tags.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries (misprediction).
- dis_valid  input  1  dispatch request.
- dis_ready  output  1  station can accept a dispatch this cycle.
- dis_unit  input  3  execution unit code (ALU, BRANCH, MUL, DIV, LOAD).
- dis_op  input  10  operation code.
- dis_pc  input  32  instruction pc.
- dis_tag  input  TAG_W  destination tag of this instruction.
- dis_rj, dis_rk  input  1 each  operand j/k already valid.
- dis_qj, dis_qk  input  TAG_W each  producer tag when the operand is not valid.
- dis_vj, dis_vk  input  32 each  operand value when valid.
- cdb_valid  input  1  result broadcast.
- cdb_tag  input  TAG_W  broadcasting producer tag.
- cdb_value  input  32  broadcast value.
- iss_valid  output  1  an entry is presented to ex.
- iss_ready  input  1  ex accepts the presented entry.
- iss_unit  output  3; iss_op  output  10; iss_pc, iss_vj, iss_vk  output  32 each; iss_tag  output  TAG_W.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Entry state: busy, unit, op, pc, tag, rj/qj/vj, rk/qk/vk, age order.
- Reset (asynchronous): all busy=0, age state cleared. Outputs: count=0, dis_ready=1, iss_valid=0, all iss_* data=0.
- dis_ready = (count < DEPTH), computed from registered state only. An issue in the same cycle does not create room for a dispatch.
- Dispatch: on dis_valid & dis_ready & !flush, write the lowest-index free entry and mark it youngest.
- CDB capture:
  - On cdb_valid, every busy entry with rj=0 and qj==cdb_tag sets vj=cdb_value, rj=1. Same rule for k.
  - Tags match only against operands not yet ready.
  - Dispatch bypass: if the dispatching operand has r=0, q==cdb_tag and cdb_valid in the same cycle, the entry is written with r=1 and v=cdb_value.
- Ready entry: busy & rj & rk, from registered state. An entry woken by the CDB at edge t is first eligible for issue in the cycle after t.
- Selection: the oldest ready entry (earliest dispatched). iss_* is driven combinationally from that entry.
  - iss_valid = any ready entry & !flush.
  - When iss_valid=0, iss_* data is don't-care.
- Issue: when iss_valid & iss_ready, clear that entry's busy at the edge. iss_* must hold stable while iss_valid & !iss_ready, unless an older entry becomes ready.
- count update: next count = count + dispatch accepted − issue accepted. Dispatch and issue in the same cycle leave count unchanged.
- Flush: at the edge, all busy=0 and count=0. A dispatch presented in the flush cycle is dropped. No issue handshake completes in the flush cycle.
- Reset mid-operation: all entries are discarded immediately. No partial issue occurs.
- Age order stays correct across arbitrary interleaving. It does not depend on entry index and does not wrap incorrectly after any number of dispatches.

Test Plan:
1. Reset, then dispatch ALU op with rj=rk=1, vj=5, vk=7, tag=3, iss_ready=1. Expected: iss_valid next cycle with vj=5, vk=7, tag=3; count returns 1→0.
2. Dispatch with rj=0, qj=2, rk=1. Hold cdb_valid=0 for 3 cycles: iss_valid stays 0. Then cdb_valid, cdb_tag=2, cdb_value=0x1234. Expected: iss_valid=1 the following cycle with iss_vj=0x1234.
3. Dispatch with qj=6 in the same cycle as CDB tag 6, value 9. Expected: entry ready immediately (bypass); issues next cycle with vj=9.
4. Fill DEPTH=4 entries, all ready, iss_ready=0. Expected: dis_ready=0 and count=4; a 5th dispatch is ignored. Raise iss_ready: issue order is tags in dispatch order.
5. Dispatch A (pending), B (ready), C (ready); wake A via CDB. Expected: B issues first, then A (now oldest ready), then C.
6. With 3 busy entries, assert flush together with dis_valid. Expected: count=0, iss_valid=0, dis_ready=1 next cycle; the dispatched instruction never issues.
